shift_add_mult_param: RTL and testbench

//  Parametrised sequential shift-add multiplier: integrated control FSM plus datapath
//  (operand, accumulator and counter registers) in one block.

---
 rtl/shift_add_mult_param.sv | 103 ++++++++++
 tb/tb_shift_add_mult_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed/unsigned per op, early exit on zero multiplier, valid/ack handshake.
module shift_add_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               valid_data,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               ack,
  output logic               busy,
  output logic               Done_Flag,
  output logic [2*WIDTH-1:0] product,
  output logic [CNT_W-1:0]   iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t             state;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               calc_exit;
  logic [2*WIDTH-1:0] acc_nxt;

  // The most-negative operand negates to itself, which read
  // unsigned is exactly its magnitude, so WIDTH bits suffice.
  assign a_neg     = signed_mode & a_in[WIDTH-1];
  assign b_neg     = signed_mode & b_in[WIDTH-1];
  assign a_mag     = a_neg ? -a_in : a_in;
  assign b_mag     = b_neg ? -b_in : b_in;
  assign calc_exit = (b_reg == '0) || (iter_count == CNT_MAX);
  assign acc_nxt   = b_reg[0] ? acc + a_reg : acc;

  // Control FSM and datapath registers, all outputs registered
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      Done_Flag  <= 1'b0;
      product    <= '0;
      iter_count <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      neg        <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (valid_data) begin
            state      <= CALC;
            busy       <= 1'b1;
            a_reg      <= {{WIDTH{1'b0}}, a_mag};
            b_reg      <= b_mag;
            neg        <= a_neg ^ b_neg;
            acc        <= '0;
            iter_count <= '0;
          end
        end
        (state == CALC): begin
          if (calc_exit) begin
            product   <= neg ? -acc : acc;
            state     <= DONE;
            Done_Flag <= 1'b1;
          end else begin
            acc        <= acc_nxt;
            a_reg      <= a_reg << 1;
            b_reg      <= b_reg >> 1;
            iter_count <= iter_count + CNT_W'(1);
          end
        end
        (state == DONE): begin
          if (ack) begin
            state     <= IDLE;
            busy      <= 1'b0;
            Done_Flag <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          Done_Flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_param.sv
// Scoreboard bench for shift_add_mult_param at WIDTH=8 and 32.
// Expected results come from plain 64-bit arithmetic.
`timescale 1ns/1ps
module tb_shift_add_mult_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v8 = 0, sm8 = 0, ack8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8;
  logic [15:0] p8;
  logic [3:0]  ic8;

  logic        v32 = 0, sm32 = 0, ack32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        busy32, done32;
  logic [63:0] p32;
  logic [5:0]  ic32;

  shift_add_mult_param #(.WIDTH(8)) u8 (
    .Clock(clk), .Reset(rst_n), .valid_data(v8),
    .signed_mode(sm8), .a_in(a8), .b_in(b8), .ack(ack8),
    .busy(busy8), .Done_Flag(done8), .product(p8),
    .iter_count(ic8)
  );

  shift_add_mult_param #(.WIDTH(32)) u32 (
    .Clock(clk), .Reset(rst_n), .valid_data(v32),
    .signed_mode(sm32), .a_in(a32), .b_in(b32), .ack(ack32),
    .busy(busy32), .Done_Flag(done32), .product(p32),
    .iter_count(ic32)
  );

  typedef struct {
    longint unsigned prod;
    int              iter;
    int              lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint unsigned act,
                     longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Product = sign/zero-extended a times b, modulo 2^(2w).
  // Steps = index of highest set bit of |b| plus one.
  function automatic exp_t ref_model(int w, bit sm,
                                     longint unsigned a,
                                     longint unsigned b);
    longint unsigned m, m2, ax, bx, bm;
    exp_t e;
    m  = (64'd1 << w) - 1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 1);
    ax = a & m;
    bx = b & m;
    if (sm && ax[w-1]) ax = ax | ~m;
    if (sm && bx[w-1]) bx = bx | ~m;
    e.prod = (ax * bx) & m2;
    bm = (sm && bx[w-1]) ? ((-bx) & m) : bx;
    e.iter = 0;
    for (int i = 0; i < w; i++)
      if (bm[i]) e.iter = i + 1;
    e.lat = e.iter + 1;
    return e;
  endfunction

  // Monitor for the 8-bit instance
  int cap8 = 0;
  bit pd8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pd8 = 0;
    end else begin
      if (v8 && !busy8) cap8 = cyc + 1;
      if (done8 && !pd8) begin
        if (q8.size() == 0) begin
          chk("w8_unexpected_done", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("w8_product", p8, e.prod);
          chk("w8_iter_count", ic8, e.iter);
          chk("w8_latency", cyc - cap8, e.lat);
        end
      end
      pd8 = done8;
    end
  end

  // Monitor for the 32-bit instance
  int cap32 = 0;
  bit pd32 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pd32 = 0;
    end else begin
      if (v32 && !busy32) cap32 = cyc + 1;
      if (done32 && !pd32) begin
        if (q32.size() == 0) begin
          chk("w32_unexpected_done", 1, 0);
        end else begin
          e = q32.pop_front();
          chk("w32_product", p32, e.prod);
          chk("w32_iter_count", ic32, e.iter);
          chk("w32_latency", cyc - cap32, e.lat);
        end
      end
      pd32 = done32;
    end
  end

  task automatic go(bit big, bit sm, longint unsigned a,
                    longint unsigned b, bit push);
    @(posedge clk); #1;
    if (big) begin
      a32 = a[31:0]; b32 = b[31:0]; sm32 = sm; v32 = 1;
      if (push) q32.push_back(ref_model(32, sm, a, b));
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; v8 = 1;
      if (push) q8.push_back(ref_model(8, sm, a, b));
    end
    @(posedge clk); #1;
    v8 = 0;
    v32 = 0;
  endtask

  task automatic wait_done(bit big, int budget, string name);
    int n = 0;
    while (!(big ? done32 : done8) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(big ? done32 : done8)) chk(name, 0, 1);
  endtask

  task automatic do_ack(bit big);
    @(posedge clk); #1;
    if (big) ack32 = 1; else ack8 = 1;
    @(posedge clk); #1;
    ack8 = 0;
    ack32 = 0;
  endtask

  task automatic op(bit big, bit sm, longint unsigned a,
                    longint unsigned b, string name);
    go(big, sm, a, b, 1);
    wait_done(big, 40, name);
    do_ack(big);
  endtask

  function automatic longint unsigned pick32();
    case ($urandom_range(0, 9))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hFFFF_FFFF;
      3: return 64'h8000_0000;
      default: return {32'h0, $urandom};
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_product8", p8, 0);
    chk("rst_iter8", ic8, 0);
    chk("rst_busy32", busy32, 0);
    chk("rst_product32", p32, 0);
    #10 rst_n = 1;

    // Unsigned 200*255 and product hold while ack stays low
    go(0, 0, 200, 255, 1);
    wait_done(0, 20, "t1_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_hold_product", p8, 16'hC738);
      chk("t1_hold_done", done8, 1);
    end
    do_ack(0);

    // Signed corners and early exit on b == 0
    op(0, 1, 8'h80, 8'h80, "t2a_timeout");
    op(0, 1, 8'hFD, 8'h05, "t2b_timeout");
    op(0, 0, 8'h7F, 8'h00, "t3a_timeout");
    op(0, 1, 8'hFF, 8'h00, "t3b_timeout");
    op(0, 1, 8'h00, 8'hFB, "t3c_timeout");

    // ack in IDLE is ignored
    @(posedge clk); #1 ack8 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_ack_idle_busy", busy8, 0);
    chk("t4_ack_idle_done", done8, 0);
    ack8 = 0;

    // valid_data pulses in CALC and DONE are ignored
    go(0, 0, 7, 6, 1);
    v8 = 1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1 v8 = 0;
    wait_done(0, 20, "t4_timeout");
    @(posedge clk); #1 v8 = 1; a8 = 3; b8 = 3; sm8 = 0;
    @(posedge clk); #1;
    chk("t4_valid_in_done", done8, 1);
    ack8 = 1;
    @(posedge clk); #1;
    chk("t4_va_busy", busy8, 0);
    chk("t4_va_done", done8, 0);
    ack8 = 0;
    q8.push_back(ref_model(8, 0, 3, 3));
    @(posedge clk); #1 v8 = 0;
    chk("t4_capture_busy", busy8, 1);
    wait_done(0, 20, "t4b_timeout");
    do_ack(0);

    // Asynchronous reset during the fourth CALC step
    go(0, 0, 8'h55, 8'hFF, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_busy", busy8, 0);
    chk("t5_rst_done", done8, 0);
    chk("t5_rst_product", p8, 0);
    chk("t5_rst_iter", ic8, 0);
    rst_n = 1;
    op(0, 0, 13, 11, "t5_timeout");

    // Randomised 32-bit ops with corner operands
    op(1, 1, 64'h8000_0000, 64'h8000_0000, "t6c_timeout");
    op(1, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "t6d_timeout");
    for (int i = 0; i < 1000; i++)
      op(1, 1'($urandom_range(0, 1)), pick32(), pick32(),
         "t6_timeout");

    repeat (3) @(posedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q32_drained", q32.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
